// File: rtl/dma_irq_coalescer.sv
// Per-channel interrupt coalescer: edge-detected DMA events become pending IRQs,
// batched by event count and/or timeout, held until ack, with ack-latency capture.

module dma_irq_coalescer_ch #(
  parameter int LAT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             M_AXI_ACLK,
  input  logic             M_AXI_ARESET,
  input  logic             evt,
  input  logic             en,
  input  logic             ack,
  input  logic [CNT_W-1:0] th,
  input  logic [LAT_W-1:0] timeout,
  output logic             pending,
  output logic [LAT_W-1:0] latency,
  output logic [CNT_W-1:0] evt_count,
  output logic             ovf
);
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ASSERT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, backlog, backlog_n, evt_count_n;
  logic [LAT_W-1:0] timer, timer_n, latency_n;
  logic             ovf_n, ev, ovf_set;

  assign ev      = evt & en;
  assign pending = (state == S_ASSERT);

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      timer     <= '0;
      backlog   <= '0;
      latency   <= '0;
      evt_count <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      timer     <= timer_n;
      backlog   <= backlog_n;
      latency   <= latency_n;
      evt_count <= evt_count_n;
      ovf       <= ovf_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    timer_n     = timer;
    backlog_n   = backlog;
    latency_n   = latency;
    evt_count_n = evt_count;
    ovf_n       = ovf;
    ovf_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (ev) begin
          cnt_n   = CNT_W'(1);
          timer_n = '0;
          if (th == CNT_W'(1)) begin
            state_n     = S_ASSERT;
            evt_count_n = CNT_W'(1);
            latency_n   = '0;
            backlog_n   = '0;
          end else begin
            state_n = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        timer_n = (timer == '1) ? timer : timer + LAT_W'(1);
        if (ev && cnt != '1) cnt_n = cnt + CNT_W'(1);
        if (!en) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt_n >= th || (timeout != '0 && timer_n >= timeout)) begin
          state_n     = S_ASSERT;
          evt_count_n = cnt_n;
          latency_n   = '0;
          backlog_n   = '0;
        end
      end
      S_ASSERT: begin
        if (ev) begin
          if (backlog == '1) ovf_set = 1'b1;
          else               backlog_n = backlog + CNT_W'(1);
        end
        if (ack) begin
          // a same-cycle overflow outlives the ack that would clear it
          ovf_n = ovf_set;
          if (backlog_n == '0) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_COLLECT;
            cnt_n   = backlog_n;
            timer_n = '0;
          end
        end else begin
          ovf_n = ovf | ovf_set;
          if (latency != '1) latency_n = latency + LAT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
endmodule

module dma_irq_coalescer #(
  parameter int NCH   = 4,
  parameter int LAT_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                 M_AXI_ACLK,
  input  logic                 M_AXI_ARESET,
  input  logic [NCH-1:0]       D,
  input  logic [NCH-1:0]       IRQ_ENABLE,
  input  logic [NCH-1:0]       IRQ_ACK,
  input  logic [CNT_W-1:0]     COAL_COUNT,
  input  logic [LAT_W-1:0]     COAL_TIMEOUT,
  output logic                 Q,
  output logic [NCH-1:0]       IRQ_PENDING,
  output logic [NCH*LAT_W-1:0] irq_latency,
  output logic [NCH*CNT_W-1:0] evt_count,
  output logic [NCH-1:0]       evt_ovf
);
  logic [NCH-1:0]   d_q, d_edge;
  logic [CNT_W-1:0] th;

  assign d_edge = D & ~d_q;
  assign th     = (COAL_COUNT == '0) ? CNT_W'(1) : COAL_COUNT;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      d_q <= '0;
      Q   <= 1'b0;
    end else begin
      d_q <= D;
      Q   <= |IRQ_PENDING;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    dma_irq_coalescer_ch #(.LAT_W(LAT_W), .CNT_W(CNT_W)) u_ch (
      .M_AXI_ACLK   (M_AXI_ACLK),
      .M_AXI_ARESET (M_AXI_ARESET),
      .evt          (d_edge[i]),
      .en           (IRQ_ENABLE[i]),
      .ack          (IRQ_ACK[i]),
      .th           (th),
      .timeout      (COAL_TIMEOUT),
      .pending      (IRQ_PENDING[i]),
      .latency      (irq_latency[i*LAT_W +: LAT_W]),
      .evt_count    (evt_count[i*CNT_W +: CNT_W]),
      .ovf          (evt_ovf[i])
    );
  end
endmodule
